// File: rtl/fifo_stream_sink_if.sv
// fifo_stream_sink_if
//   Read port of a first-word-fall-through FIFO.
//   fifo_dout    : head data. It is valid whenever fifo_empty_n=1.
//   fifo_empty_n : the FIFO holds at least one beat.
//   fifo_read    : pop request. A beat transfers when fifo_read & fifo_empty_n.
//   master : the FIFO side, which drives data and status.
//   slave  : the consumer side, which drives the pop request.
interface fifo_stream_sink_if #(
  parameter int DATA_WIDTH = 512
);
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty_n;
  logic                  fifo_read;

  modport master (output fifo_dout, output fifo_empty_n, input fifo_read);
  modport slave  (input fifo_dout, input fifo_empty_n, output fifo_read);
endinterface

// File: rtl/fifo_stream_sink.sv
// fifo_stream_sink
//   Consumes an expected number of beats from a FWFT FIFO after an ap_start pulse.
//   Reads can be spaced out with throttle. The block keeps a beat count and a
//   rotate-XOR checksum of the consumed data. A run ends in DONE when the last
//   beat transfers, or in ERR when no beat transfers for TIMEOUT_CYCLES cycles.
// Ports
//   ap_clk, ap_rst_n : clock and asynchronous active-low reset.
//   ap_start         : 1-cycle start pulse. It latches expected_beats and throttle.
//   expected_beats   : number of beats to consume in this run.
//   throttle         : N allows at most one read per N+1 cycles.
//   fifo_if          : FIFO read port (slave modport).
//   ap_idle          : 1 in IDLE, DONE and ERR.
//   ap_done          : 1-cycle pulse on entry to DONE or ERR.
//   beat_cnt         : beats consumed in the current or last run.
//   checksum         : running signature of the consumed data.
//   timeout_err      : sticky flag, set when a run ends by timeout.
//   extra_data       : sticky flag, set when the FIFO is non-empty while in DONE.
module fifo_stream_sink #(
  parameter int DATA_WIDTH     = 512,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 ap_start,
  input  logic [CNT_WIDTH-1:0] expected_beats,
  input  logic [3:0]           throttle,
  fifo_stream_sink_if.slave    fifo_if,
  output logic                 ap_idle,
  output logic                 ap_done,
  output logic [CNT_WIDTH-1:0] beat_cnt,
  output logic [31:0]          checksum,
  output logic                 timeout_err,
  output logic                 extra_data
);

  localparam int LANES = DATA_WIDTH / 32;
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  // XOR of all 32-bit lanes of one beat
  function automatic logic [31:0] fold_lanes(input logic [DATA_WIDTH-1:0] d);
    logic [31:0] acc;
    acc = 32'd0;
    for (int i = 0; i < LANES; i++) begin
      acc = acc ^ d[i*32 +: 32];
    end
    return acc;
  endfunction

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] exp_q, exp_d;
  logic [3:0]           thr_q, thr_d;
  logic [3:0]           phase_q, phase_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          sum_q, sum_d;
  logic                 done_q, done_d;
  logic                 tout_q, tout_d;
  logic                 extra_q, extra_d;

  logic run_s;
  logic last_s;
  logic rd_s;

  assign run_s  = (state_q == S_RUN);
  assign last_s = (cnt_q == exp_q);
  // fifo_read already includes fifo_empty_n, so every read is a transfer.
  assign rd_s   = run_s & fifo_if.fifo_empty_n & (phase_q == 4'd0) & ~last_s;

  assign fifo_if.fifo_read = rd_s;
  assign ap_idle     = ~run_s;
  assign ap_done     = done_q;
  assign beat_cnt    = cnt_q;
  assign checksum    = sum_q;
  assign timeout_err = tout_q;
  assign extra_data  = extra_q;

  // Next-state logic for the FSM, counters and flags
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    thr_d   = thr_q;
    phase_d = phase_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    done_d  = 1'b0;
    tout_d  = tout_q;
    extra_d = extra_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (ap_start) begin
          state_d = S_RUN;
          exp_d   = expected_beats;
          thr_d   = throttle;
          phase_d = 4'd0;
          timer_d = '0;
          cnt_d   = '0;
          sum_d   = 32'd0;
          tout_d  = 1'b0;
          extra_d = 1'b0;
        end else if ((state_q == S_DONE) && fifo_if.fifo_empty_n) begin
          extra_d = 1'b1;
        end else begin
          extra_d = extra_q;
        end
      end
      S_RUN: begin
        // The phase advances every RUN cycle, whether data is present or not.
        phase_d = (phase_q == thr_q) ? 4'd0 : (phase_q + 4'd1);
        if (rd_s) begin
          cnt_d   = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          sum_d   = {sum_q[30:0], sum_q[31]} ^ fold_lanes(fifo_if.fifo_dout);
          timer_d = '0;
          if ((cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1}) == exp_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else if (last_s) begin
          // Reached only when the run was started with expected_beats == 0.
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          state_d = S_ERR;
          done_d  = 1'b1;
          tout_d  = 1'b1;
        end else begin
          timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      exp_q   <= '0;
      thr_q   <= 4'd0;
      phase_q <= 4'd0;
      timer_q <= '0;
      cnt_q   <= '0;
      sum_q   <= 32'd0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      extra_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      thr_q   <= thr_d;
      phase_q <= phase_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
      extra_q <= extra_d;
    end
  end

endmodule
